gauss_window_gen: RTL and testbench
===================================

# gauss_window_gen

Streaming 3x3 window generator feeding the Gaussian convolution pipeline. It accepts a raster-order 8-bit pixel stream with valid/ready/last flow control and buffers two previous image lines. It emits one 72-bit 3x3 neighbourhood per interior pixel, with valid/last, honouring downstream backpressure. It is the producer end of the convolution stage's window interface.

## Interface
- IMG_WIDTH, 512, pixels per line (>= 3)
- IMG_HEIGHT, 512, lines per frame (>= 3)
- i_clk  in  1  clock
- i_rst  in  1  asynchronous, active-high reset
- i_pixel_data  in  8  input pixel
- i_pixel_data_valid  in  1  input pixel valid
- i_pixel_data_last  in  1  final pixel of frame
- o_pixel_data_ready  out  1  block can accept a pixel this cycle
- o_window_data  out  72  3x3 window; byte i at [i*8+:8], i = r*3+c, r=0 top (oldest) row, c=0 leftmost (oldest) column
- o_window_valid  out  1  window valid
- o_window_last  out  1  final window of frame
- i_window_ready  in  1  downstream accepts window
- o_frame_err  out  1  framing error pulse (only with WINGEN_FRAME_CHECK_EN)

## Operation
- Pixel accepted when i_pixel_data_valid && o_pixel_data_ready.
- o_pixel_data_ready = !o_window_valid || i_window_ready (combinational).
- Counters col (0..IMG_WIDTH-1) and row (0..IMG_HEIGHT-1) advance per accepted pixel. col wraps to 0 with row+1. After (IMG_HEIGHT-1, IMG_WIDTH-1), both return to 0.
- Two line buffers hold rows r-1 and r-2. At address col they are read before write: lb1 <= lb0[col], lb0 <= pixel.
- Column vector {lb1[col], lb0[col], pixel} is shifted into a 3x3 register array; the oldest column drops out.
- FSM:
  - S_FILL: row < 2; no windows produced.
  - S_STREAM: row >= 2; a window is produced on each accepted pixel with col >= 2.
  - Transition from S_STREAM to S_FILL at frame end.
- Produced window is centred on (row-1, col-1). Output count per frame is (IMG_WIDTH-2)*(IMG_HEIGHT-2).
- o_window_last = 1 only for the window produced by pixel (IMG_HEIGHT-1, IMG_WIDTH-1).
- An accepted pixel with i_pixel_data_last = 1 always resets col/row to 0 and the FSM to S_FILL (resync), whether or not the position is correct.
- Output stage:
  - Holds o_window_data/valid/last stable while o_window_valid && !i_window_ready.
  - Clears o_window_valid on handshake when no new window is produced.

## Timing
- Reset: all outputs 0; col = row = 0; state S_FILL; window registers 0. Line buffer contents are not reset.
- Latency: window appears one cycle after the accepting edge of its completing pixel.
- Throughput: one pixel/window per cycle when i_window_ready is held high.
- Simultaneous window handshake and new window production: new window is loaded with no bubble.
- Reset asserted mid-frame: immediate return to reset state; the next accepted pixel is treated as (0,0).

## Configuration
- WINGEN_FRAME_CHECK_EN defined:
  - o_frame_err exists.
  - Pulses 1 cycle (registered) when an accepted pixel has last=1 at a position other than (IMG_HEIGHT-1, IMG_WIDTH-1), or last=0 at that position.
  - Reset value 0.
- Not defined: port and logic are absent; resync behaviour is unchanged.

## Structure
- gauss_pkg holds PIXEL_W=8, KERNEL_DIM=3, WINDOW_W=72, and the FSM state typedef (S_FILL, S_STREAM).
- Sub-module gauss_line_buffer: parameterised IMG_WIDTH x 8 single-port memory with read-before-write and a write-enable. Instantiated twice.

## Test plan
- IMG_WIDTH=5, IMG_HEIGHT=4; ramp pixel = row*5+col; i_window_ready=1.
  -> 6 windows.
  -> First window bytes 0..8 = 0,1,2,5,6,7,10,11,12, last=0.
  -> Final window = 7,8,9,12,13,14,17,18,19, last=1.
- Same stream, i_window_ready toggled 1/0 each cycle.
  -> Identical 6 windows.
  -> Data is stable while stalled.
  -> o_pixel_data_ready=0 whenever valid && !ready.
- Two back-to-back frames with different ramps.
  -> 12 windows, each frame correct; no window mixes rows across frames.
- i_rst pulsed after 9 pixels, then a full frame sent.
  -> Outputs are 0 during reset.
  -> Exactly 6 correct windows follow.
- WINGEN_FRAME_CHECK_EN, last=1 on pixel 12.
  -> o_frame_err pulses once.
  -> The next frame produces 6 correct windows.
- Input valid gaps of random length.
  -> Window sequence matches the gap-free run.

Source files
------------

// File: rtl/gauss_pkg.sv
// gauss_pkg: shared widths, FSM state type and window packing helper for the 3x3 window generator
package gauss_pkg;
  localparam int PIXEL_W = 8;
  localparam int KERNEL_DIM = 3;
  localparam int WINDOW_W = PIXEL_W * KERNEL_DIM * KERNEL_DIM;
  typedef enum logic {S_FILL, S_STREAM} state_t;
  typedef logic [KERNEL_DIM-1:0][PIXEL_W-1:0] column_t;
  function automatic logic [WINDOW_W-1:0] pack_window(column_t l, column_t m, column_t n);
    logic [WINDOW_W-1:0] w;
    w = '0;
    for (int r = 0; r < KERNEL_DIM; r++) begin
      w[(r*KERNEL_DIM)*PIXEL_W +: PIXEL_W] = l[r];
      w[(r*KERNEL_DIM+1)*PIXEL_W +: PIXEL_W] = m[r];
      w[(r*KERNEL_DIM+2)*PIXEL_W +: PIXEL_W] = n[r];
    end
    return w;
  endfunction
endpackage

// File: rtl/gauss_window_gen_if.sv
// gauss_window_gen_if: pixel stream in and 3x3 window stream out between producer and convolution stage
interface gauss_window_gen_if;
  import gauss_pkg::*;
  logic [PIXEL_W-1:0] pixel_data;
  logic pixel_data_valid;
  logic pixel_data_last;
  logic pixel_data_ready;
  logic [WINDOW_W-1:0] window_data;
  logic window_valid;
  logic window_last;
  logic window_ready;
  modport master(output pixel_data, pixel_data_valid, pixel_data_last, window_ready,
                 input pixel_data_ready, window_data, window_valid, window_last);
  modport slave(input pixel_data, pixel_data_valid, pixel_data_last, window_ready,
                output pixel_data_ready, window_data, window_valid, window_last);
endinterface

// File: rtl/gauss_line_buffer.sv
// gauss_line_buffer: one image line of pixels, single port, read-before-write
module gauss_line_buffer
  import gauss_pkg::*;
#(
  parameter int DEPTH = 512
) (
  input  logic                     i_clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] addr,
  input  logic [PIXEL_W-1:0]       wr_data,
  output logic [PIXEL_W-1:0]       rd_data
);
  logic [PIXEL_W-1:0] mem [DEPTH];
  assign rd_data = mem[addr];
  // store the incoming pixel; the old value is visible on rd_data until the edge
  always_ff @(posedge i_clk)
    if (we) mem[addr] <= wr_data;
endmodule

// File: rtl/gauss_window_gen.sv
// gauss_window_gen: streaming 3x3 window generator; WINGEN_FRAME_CHECK_EN adds o_frame_err
module gauss_window_gen
  import gauss_pkg::*;
#(
  parameter int IMG_WIDTH  = 512,
  parameter int IMG_HEIGHT = 512
) (
  input logic i_clk,
  input logic i_rst,
  gauss_window_gen_if.slave win_if
`ifdef WINGEN_FRAME_CHECK_EN
  ,
  output logic o_frame_err
`endif
);
  localparam int CW = $clog2(IMG_WIDTH);
  localparam int RW = $clog2(IMG_HEIGHT);
  localparam logic [CW-1:0] COL_MAX = CW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0] ROW_MAX = RW'(IMG_HEIGHT - 1);
  logic [CW-1:0] col;
  logic [RW-1:0] row;
  state_t state;
  logic [PIXEL_W-1:0] lb0_rd, lb1_rd;
  column_t c0, c1, nc;
  logic acc, frame_end, produce;
  assign win_if.pixel_data_ready = !win_if.window_valid || win_if.window_ready;
  assign acc = win_if.pixel_data_valid && win_if.pixel_data_ready;
  assign frame_end = row == ROW_MAX && col == COL_MAX;
  assign produce = acc && state == S_STREAM && col >= CW'(2);
  assign nc = {win_if.pixel_data, lb0_rd, lb1_rd};
  gauss_line_buffer #(.DEPTH(IMG_WIDTH)) u_lb0 (
    .i_clk(i_clk), .we(acc), .addr(col), .wr_data(win_if.pixel_data), .rd_data(lb0_rd)
  );
  gauss_line_buffer #(.DEPTH(IMG_WIDTH)) u_lb1 (
    .i_clk(i_clk), .we(acc), .addr(col), .wr_data(lb0_rd), .rd_data(lb1_rd)
  );
  // raster position, fill/stream FSM, column history and registered window output
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) begin
      col <= '0;
      row <= '0;
      state <= S_FILL;
      c0 <= '0;
      c1 <= '0;
      win_if.window_data <= '0;
      win_if.window_valid <= 1'b0;
      win_if.window_last <= 1'b0;
    end else begin
      if (produce) begin
        win_if.window_data <= pack_window(c0, c1, nc);
        win_if.window_valid <= 1'b1;
        win_if.window_last <= frame_end;
      end else if (win_if.window_ready) begin
        win_if.window_valid <= 1'b0;
        win_if.window_last <= 1'b0;
      end
      if (acc) begin
        c0 <= c1;
        c1 <= nc;
        if (win_if.pixel_data_last || frame_end) begin
          col <= '0;
          row <= '0;
          state <= S_FILL;
        end else if (col == COL_MAX) begin
          col <= '0;
          row <= row + RW'(1);
          state <= row == RW'(1) ? S_STREAM : state;
        end else col <= col + CW'(1);
      end
    end
`ifdef WINGEN_FRAME_CHECK_EN
  // flag a last marker that disagrees with the raster position
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) o_frame_err <= 1'b0;
    else o_frame_err <= acc && (win_if.pixel_data_last != frame_end);
`endif
endmodule

// File: tb/tb_gauss_window_gen.sv
// tb_gauss_window_gen: directed frames on a 5x4 image checked against a coordinate model of the windows
module tb_gauss_window_gen;
  localparam int W = 5;
  localparam int H = 4;
  logic i_clk = 1'b0;
  logic i_rst = 1'b1;
  gauss_window_gen_if bus ();
`ifdef WINGEN_FRAME_CHECK_EN
  logic o_frame_err;
`endif
  gauss_window_gen #(.IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
    .i_clk(i_clk),
    .i_rst(i_rst),
    .win_if(bus)
`ifdef WINGEN_FRAME_CHECK_EN
    , .o_frame_err(o_frame_err)
`endif
  );
  always #5 i_clk = ~i_clk;
  int n_chk = 0;
  int n_pass = 0;
  int err_cnt = 0;
  bit tog = 0;
  bit prev_stall = 0;
  logic [72:0] prev_w;
  logic [72:0] got_q[$];
  logic [72:0] exp_q[$];
  task automatic check(string tag, logic [72:0] got, logic [72:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask
  function automatic logic [71:0] model_win(int base, int r, int c);
    logic [71:0] w;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        w[(i*3+j)*8 +: 8] = 8'(base + (r - 2 + i) * W + (c - 2 + j));
    return w;
  endfunction
  task automatic exp_frame(int base, int n);
    for (int k = 0; k < n; k++)
      if (k / W >= 2 && k % W >= 2)
        exp_q.push_back({k == W * H - 1, model_win(base, k / W, k % W)});
  endtask
  initial forever begin
    @(posedge i_clk);
    #1;
    bus.window_ready = tog ? ~bus.window_ready : 1'b1;
  end
  initial forever begin
    @(negedge i_clk);
    if (!i_rst) begin
      if (bus.window_valid && bus.window_ready) got_q.push_back({bus.window_last, bus.window_data});
      if (prev_stall) check("hold", {bus.window_last, bus.window_data}, prev_w);
      if (bus.window_valid && !bus.window_ready) check("rdy_stall", bus.pixel_data_ready, 0);
      prev_stall = bus.window_valid && !bus.window_ready;
      prev_w = {bus.window_last, bus.window_data};
`ifdef WINGEN_FRAME_CHECK_EN
      if (o_frame_err) err_cnt++;
`endif
    end
  end
  task automatic send(int base, int n, int last_idx, bit gap);
    for (int k = 0; k < n; k++) begin
      int g;
      int t;
      bit acc;
      g = gap ? int'($urandom_range(0, 3)) : 0;
      bus.pixel_data_valid = 1'b0;
      repeat (g) begin
        @(posedge i_clk);
        #1;
      end
      bus.pixel_data = 8'(base + k);
      bus.pixel_data_valid = 1'b1;
      bus.pixel_data_last = k == last_idx;
      t = 0;
      acc = 0;
      while (!acc && t < 50) begin
        @(negedge i_clk);
        acc = bus.pixel_data_ready;
        @(posedge i_clk);
        #1;
        t++;
      end
      if (!acc) check("accept_timeout", 0, 1);
    end
    bus.pixel_data_valid = 1'b0;
    bus.pixel_data_last = 1'b0;
  endtask
  task automatic settle();
    tog = 0;
    repeat (6) begin
      @(posedge i_clk);
      #1;
    end
  endtask
  task automatic compare(string tag);
    check({tag, "_count"}, 73'(got_q.size()), 73'(exp_q.size()));
    foreach (exp_q[i])
      if (i < got_q.size()) check(tag, got_q[i], exp_q[i]);
    got_q.delete();
    exp_q.delete();
  endtask
  initial begin
    bus.pixel_data = '0;
    bus.pixel_data_valid = 1'b0;
    bus.pixel_data_last = 1'b0;
    bus.window_ready = 1'b1;
    repeat (3) @(posedge i_clk);
    #1;
    check("rst_data", bus.window_data, 0);
    check("rst_valid", bus.window_valid, 0);
    check("rst_last", bus.window_last, 0);
    check("rst_ready", bus.pixel_data_ready, 1);
    i_rst = 1'b0;
    @(posedge i_clk);
    #1;
    exp_frame(0, W * H);
    send(0, W * H, W * H - 1, 0);
    settle();
    check("first_win", got_q[0], {1'b0, 72'h0c0b0a070605020100});
    check("final_win", got_q[5], {1'b1, 72'h1312110e0d0c090807});
    compare("ramp");
    tog = 1;
    exp_frame(0, W * H);
    send(0, W * H, W * H - 1, 0);
    settle();
    compare("toggle");
    exp_frame(0, W * H);
    exp_frame(30, W * H);
    send(0, W * H, W * H - 1, 0);
    send(30, W * H, W * H - 1, 0);
    settle();
    compare("b2b");
    send(0, 9, -1, 0);
    i_rst = 1'b1;
    #1;
    check("mid_rst_valid", bus.window_valid, 0);
    check("mid_rst_data", bus.window_data, 0);
    @(posedge i_clk);
    #1;
    check("mid_rst_last", bus.window_last, 0);
    i_rst = 1'b0;
    exp_frame(50, W * H);
    send(50, W * H, W * H - 1, 0);
    settle();
    compare("after_rst");
    exp_frame(100, 13);
    exp_frame(200, W * H);
    send(100, 13, 12, 0);
    send(200, W * H, W * H - 1, 0);
    settle();
    compare("resync");
`ifdef WINGEN_FRAME_CHECK_EN
    check("frame_err_pulses", 73'(err_cnt), 73'(1));
`endif
    exp_frame(0, W * H);
    send(0, W * H, W * H - 1, 1);
    settle();
    compare("gaps");
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
